dsp_mac_sequencer: RTL and testbench
====================================

Name: dsp_mac_sequencer

Overview:
- Sequences one DSP48A1 slice as a signed multiply-accumulate (dot-product) engine.
- Accepts a valid/ready stream of 18-bit A/B operand pairs terminated by s_last.
- Drives the slice's operand, OPMODE, clock-enable and reset pins, then returns the 48-bit accumulated P on a valid/ready result port.
- Sits between the operand producer and the DSP48A1 instance, which is configured with all pipeline registers enabled.

Parameters:
- DSP_LAT, 4: cycles from DSP_A/DSP_B at the slice ports to the corresponding P at DSP_P (A0/B0, B1, M, P registers).
- OPM_DLY, 2: cycles the per-operand OPMODE is delayed so it reaches the post-adder together with its M product.
- CNT_W, 16: width of the operand counter.

Ports:
- CLK  in  1  clock.
- RSTN  in  1  asynchronous active-low reset.
- s_valid  in  1  operand pair valid.
- s_ready  out  1  operand pair accepted when s_valid && s_ready.
- s_a  in  18  signed multiplicand.
- s_b  in  18  signed multiplier.
- s_last  in  1  final pair of the sequence.
- abort  in  1  synchronous abort of the current sequence.
- m_valid  out  1  result valid.
- m_ready  in  1  result consumed.
- m_data  out  48  accumulated signed result.
- m_count  out  CNT_W  number of pairs accumulated.
- DSP_A  out  18  to slice A.
- DSP_B  out  18  to slice B.
- DSP_C  out  48  to slice C, tied to 0.
- DSP_D  out  18  to slice D, tied to 0.
- DSP_OPMODE  out  8  to slice OPMODE.
- DSP_CE  out  1  drives CEA/CEB/CEM/CEP/CEOPMODE.
- DSP_RST  out  1  drives all slice RST* pins, active-high, synchronous at the slice.
- DSP_P  in  48  slice P output.

Behaviour:
- Clock and reset: one clock, CLK. RSTN is asynchronous and active-low.
- Reset values: s_ready=0, m_valid=0, m_data=0, m_count=0, DSP_A=0, DSP_B=0, DSP_OPMODE=8'h00, DSP_CE=0, DSP_RST=1, state=IDLE, tag pipe cleared.
- DSP_RST stays 1 for exactly one cycle after RSTN deasserts.
- OPMODE encoding: FIRST=8'h01 (X=M, Z=0); ACC=8'h09 (X=M, Z=P); IDLE=8'h00.
- States: IDLE, RUN, DRAIN, HOLD.
- IDLE:
  - s_ready=1 and DSP_CE=1.
  - On accept: register s_a/s_b onto DSP_A/DSP_B next cycle, tag that slot FIRST, count=1.
  - If s_last is also set, go to DRAIN; otherwise go to RUN.
- RUN:
  - s_ready=1.
  - On accept: drive the pair tagged ACC and increment count.
  - With no accept: drive a bubble (A=B=0, ACC). A bubble adds 0, so no CE gating is required.
  - Accept with s_last goes to DRAIN.
- Tag pipe: a {first,last} tag shift register travels alongside each slot.
  - The OPMODE for a slot is output OPM_DLY cycles after its operands.
  - The last tag emerges DSP_LAT cycles after the operands.
- DRAIN:
  - s_ready=0; feed bubbles.
  - When the last tag emerges, capture DSP_P into m_data and count into m_count, set m_valid=1, go to HOLD.
- Latency: last pair accepted at cycle t → DSP_A at t+1 → m_valid at t+DSP_LAT+2 (6 cycles at the default).
- HOLD:
  - m_valid, m_data and m_count stay stable until m_ready.
  - The handshake cycle clears m_valid and returns to IDLE.
  - s_ready=0 while in HOLD; DSP_CE=0, so the slice freezes.
- Arithmetic: 18×18 signed yields a 36-bit product, sign-extended to 48 bits and accumulated. Wrap-around is modulo 2^48 with no saturation.
- Count saturates at 2^CNT_W−1; the accumulation itself continues.
- abort: in any state, the next cycle gives state=IDLE, m_valid=0, tag pipe cleared, DSP_RST pulsed for 1 cycle, s_ready=0 during that cycle.
- abort takes priority over a simultaneous accept or m_ready.
- RSTN assertion mid-sequence immediately restores the reset values; the partial sum is discarded.

Decomposition:
- Shared package dsp_ctrl_pkg holds:
  - OPMODE constants OPM_IDLE/OPM_FIRST/OPM_ACC;
  - X/Z mux field localparams;
  - state enum encoding.
- One sub-module, dsp_tag_pipe: a parameterised-depth shift register carrying {valid,first,last} with taps at OPM_DLY and DSP_LAT.

Test Plan:
- Pairs (2,3),(4,5)+last, back-to-back, m_ready=1 → m_data=26, m_count=2; m_valid exactly 6 cycles after the last accept.
- Single pair (−7,3)+last → m_data=48'hFFFF_FFFF_FFEB, m_count=1.
- Pairs (1,1),(2,2),(3,3)+last with s_valid low for 3 cycles between each → m_data=14; DSP_OPMODE=8'h09 on every bubble.
- m_ready held 0 for 10 cycles after m_valid → m_data stable; s_ready=0, DSP_CE=0 throughout; one cycle after m_ready, s_ready=1.
- abort asserted two cycles after the 2nd pair → DSP_RST high 1 cycle, no m_valid; new sequence (6,7)+last → m_data=42, m_count=1.
- Sequence (131071,131071)×2 +last → m_data=2·131071²=34359214082; then RSTN pulsed low mid-RUN of a new sequence → all outputs at reset values, DSP_RST high one cycle after release.

Source files
------------

// File: rtl/dsp_ctrl_pkg.sv
// Shared definitions for the DSP48A1 MAC sequencer.
//   - X/Z multiplexer field codes of the slice OPMODE bus
//   - OPMODE words used by the sequencer (idle, first product, accumulate)
//   - FSM state encoding and the per-slot tag carried alongside the slice pipeline
package dsp_ctrl_pkg;

  // OPMODE[1:0] selects the X multiplexer, OPMODE[3:2] the Z multiplexer.
  localparam logic [1:0] X_ZERO = 2'b00;
  localparam logic [1:0] X_M    = 2'b01;
  localparam logic [1:0] Z_ZERO = 2'b00;
  localparam logic [1:0] Z_P    = 2'b10;

  localparam logic [7:0] OPM_IDLE  = 8'h00;
  localparam logic [7:0] OPM_FIRST = {4'h0, Z_ZERO, X_M};  // P = M
  localparam logic [7:0] OPM_ACC   = {4'h0, Z_P, X_M};     // P = P + M

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  // valid: slot belongs to a sequence (operand pair or in-sequence bubble)
  // first: slot starts a new sum (Z = 0)
  // last : slot carries the final pair; its P is the result
  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } tag_t;

  function automatic logic [7:0] tag_opmode(input logic valid, input logic first);
    if (!valid)     return OPM_IDLE;
    else if (first) return OPM_FIRST;
    else            return OPM_ACC;
  endfunction

endpackage

// File: rtl/dsp_tag_pipe.sv
// Tag shift register that travels alongside the DSP48A1 pipeline.
// Stage 0 is loaded on the same edge that loads DSP_A/DSP_B, so stage k
// describes the slot whose operands were at the slice ports k cycles ago.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : shift enable (mirrors the slice clock enable)
//   clr        : synchronous clear of every stage
//   tag_in     : tag for the slot being presented this cycle
//   opm_valid/opm_first : tag at OPM_DLY, used to form OPMODE
//   last_out   : a last tag has reached DSP_LAT, i.e. P holds the result
module dsp_tag_pipe
  import dsp_ctrl_pkg::*;
#(
  parameter int unsigned OPM_DLY = 2,
  parameter int unsigned DSP_LAT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  input  tag_t tag_in,
  output logic opm_valid,
  output logic opm_first,
  output logic last_out
);

  tag_t pipe [0:DSP_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i <= DSP_LAT; i++) pipe[i] <= '0;
    end else if (clr) begin
      for (int unsigned i = 0; i <= DSP_LAT; i++) pipe[i] <= '0;
    end else if (en) begin
      pipe[0] <= tag_in;
      for (int unsigned i = 1; i <= DSP_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign opm_valid = pipe[OPM_DLY].valid;
  assign opm_first = pipe[OPM_DLY].first;
  assign last_out  = pipe[DSP_LAT].valid && pipe[DSP_LAT].last;

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Sequences one DSP48A1 slice (all pipeline registers enabled) as a signed
// multiply-accumulate engine over a valid/ready stream of A/B pairs.
//   CLK, RSTN                 : clock, asynchronous active-low reset
//   s_valid/s_ready/s_a/s_b/s_last : operand stream, s_last marks the final pair
//   abort                     : synchronous abort of the current sequence
//   m_valid/m_ready/m_data/m_count : result port (48-bit sum, pair count)
//   DSP_A/B/C/D/OPMODE/CE/RST : slice control, DSP_P : slice P output
module dsp_mac_sequencer
  import dsp_ctrl_pkg::*;
#(
  parameter int unsigned DSP_LAT = 4,
  parameter int unsigned OPM_DLY = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [17:0]      s_a,
  input  logic [17:0]      s_b,
  input  logic             s_last,
  input  logic             abort,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [47:0]      m_data,
  output logic [CNT_W-1:0] m_count,
  output logic [17:0]      DSP_A,
  output logic [17:0]      DSP_B,
  output logic [47:0]      DSP_C,
  output logic [17:0]      DSP_D,
  output logic [7:0]       DSP_OPMODE,
  output logic             DSP_CE,
  output logic             DSP_RST,
  input  logic [47:0]      DSP_P
);

  state_t           state, state_nx;
  logic             dsp_rst;
  logic [17:0]      a_q, b_q, a_nx, b_nx;
  logic [CNT_W-1:0] count_q, count_nx;
  logic             m_valid_q;
  logic [47:0]      m_data_q;
  logic [CNT_W-1:0] m_count_q;
  tag_t             tag_in;
  logic             opm_valid, opm_first, last_out;
  logic             accept, capture, release_res;

  // dsp_rst is high for the cycle after reset release or abort; gating
  // s_ready and CE with it keeps that cycle free of new operands.
  assign s_ready = ((state == ST_IDLE) || (state == ST_RUN)) && !dsp_rst;
  assign DSP_CE  = (state != ST_HOLD) && !dsp_rst;
  assign accept  = s_valid && s_ready;

  always_comb begin
    state_nx    = state;
    tag_in      = '0;
    a_nx        = '0;
    b_nx        = '0;
    count_nx    = count_q;
    capture     = 1'b0;
    release_res = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          a_nx         = s_a;
          b_nx         = s_b;
          tag_in.valid = 1'b1;
          tag_in.first = 1'b1;
          tag_in.last  = s_last;
          count_nx     = CNT_W'(1);
          state_nx     = s_last ? ST_DRAIN : ST_RUN;
        end
      end
      ST_RUN: begin
        // Bubbles are zero operands with ACC opmode: they add nothing.
        tag_in.valid = 1'b1;
        if (accept) begin
          a_nx        = s_a;
          b_nx        = s_b;
          tag_in.last = s_last;
          if (count_q != '1) count_nx = count_q + CNT_W'(1);
          if (s_last) state_nx = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        tag_in.valid = 1'b1;
        if (last_out) begin
          capture  = 1'b1;
          state_nx = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (m_ready) begin
          release_res = 1'b1;
          state_nx    = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
    if (abort) begin
      state_nx = ST_IDLE;
      tag_in   = '0;
      a_nx     = '0;
      b_nx     = '0;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state     <= ST_IDLE;
      dsp_rst   <= 1'b1;
      a_q       <= '0;
      b_q       <= '0;
      count_q   <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_count_q <= '0;
    end else begin
      state   <= state_nx;
      dsp_rst <= abort;
      a_q     <= a_nx;
      b_q     <= b_nx;
      count_q <= count_nx;
      if (abort) begin
        m_valid_q <= 1'b0;
      end else if (capture) begin
        m_valid_q <= 1'b1;
        m_data_q  <= DSP_P;
        m_count_q <= count_q;
      end else if (release_res) begin
        m_valid_q <= 1'b0;
      end
    end
  end

  dsp_tag_pipe #(
    .OPM_DLY(OPM_DLY),
    .DSP_LAT(DSP_LAT)
  ) u_tag_pipe (
    .clk      (CLK),
    .rst_n    (RSTN),
    .en       (DSP_CE),
    .clr      (abort),
    .tag_in   (tag_in),
    .opm_valid(opm_valid),
    .opm_first(opm_first),
    .last_out (last_out)
  );

  assign DSP_OPMODE = tag_opmode(opm_valid, opm_first);
  assign DSP_A      = a_q;
  assign DSP_B      = b_q;
  assign DSP_C      = '0;
  assign DSP_D      = '0;
  assign DSP_RST    = dsp_rst;
  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign m_count    = m_count_q;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
module tb_dsp_mac_sequencer;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        s_valid, s_ready, s_last, abort;
  logic [17:0] s_a, s_b;
  logic        m_valid, m_ready;
  logic [47:0] m_data;
  logic [15:0] m_count;
  logic [17:0] DSP_A, DSP_B, DSP_D;
  logic [47:0] DSP_C, DSP_P;
  logic [7:0]  DSP_OPMODE;
  logic        DSP_CE, DSP_RST;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int acc_cyc = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  dsp_mac_sequencer #(.DSP_LAT(4), .OPM_DLY(2), .CNT_W(16)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b), .s_last(s_last),
    .abort(abort),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_count(m_count),
    .DSP_A(DSP_A), .DSP_B(DSP_B), .DSP_C(DSP_C), .DSP_D(DSP_D),
    .DSP_OPMODE(DSP_OPMODE), .DSP_CE(DSP_CE), .DSP_RST(DSP_RST), .DSP_P(DSP_P)
  );

  // Behavioural DSP48A1: A0/A1, B0/B1, M, P and OPMODE registers enabled.
  logic signed [17:0] a0, a1, b0, b1;
  logic signed [47:0] mreg;
  logic [47:0]        preg;
  logic [7:0]         opm_r;
  always @(posedge CLK) begin
    if (DSP_RST) begin
      a0 <= '0; a1 <= '0; b0 <= '0; b1 <= '0;
      mreg <= '0; preg <= '0; opm_r <= '0;
    end else if (DSP_CE) begin
      a0    <= DSP_A;
      b0    <= DSP_B;
      a1    <= a0;
      b1    <= b0;
      mreg  <= 48'(a1) * 48'(b1);
      opm_r <= DSP_OPMODE;
      preg  <= ((opm_r[3:2] == 2'b10) ? preg : 48'd0) +
               ((opm_r[1:0] == 2'b01) ? mreg : 48'd0);
    end
  end
  assign DSP_P = preg;

  task automatic send_pair(input logic [17:0] a, input logic [17:0] b, input logic last);
    logic done;
    done = 1'b0;
    s_a = a; s_b = b; s_last = last; s_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (s_ready) begin
        acc_cyc = cyc;
        done = 1'b1;
      end
      @(negedge CLK);
      if (done) break;
    end
    s_valid = 1'b0; s_last = 1'b0;
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL accept: pair a=%0h not accepted within 20 cycles, s_ready=%b required 1", a, s_ready);
    end
  endtask

  task automatic wait_result(output logic found, output int lat);
    found = 1'b0;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      if (m_valid) begin
        found = 1'b1;
        lat = cyc - acc_cyc;
        break;
      end
      @(negedge CLK);
    end
    tests++;
    if (found !== 1'b1) begin
      fails++;
      $display("FAIL m_valid_timeout: m_valid=%b required 1 within 40 cycles", m_valid);
    end
  endtask

  task automatic test_reset();
    RSTN = 1'b0; s_valid = 1'b0; s_last = 1'b0; abort = 1'b0; m_ready = 1'b1;
    s_a = '0; s_b = '0;
    repeat (3) @(negedge CLK);
    tests++;
    if ({s_ready, m_valid, DSP_CE, DSP_RST} !== 4'b0001) begin
      fails++;
      $display("FAIL reset_ctrl: s_ready,m_valid,CE,RST=%b required 0001", {s_ready, m_valid, DSP_CE, DSP_RST});
    end
    tests++;
    if ({m_data, m_count, DSP_A, DSP_B, DSP_OPMODE} !== '0) begin
      fails++;
      $display("FAIL reset_data: m_data=%0h m_count=%0h A=%0h B=%0h OPMODE=%0h required all 0",
               m_data, m_count, DSP_A, DSP_B, DSP_OPMODE);
    end
    RSTN = 1'b1;
    #1;
    tests++;
    if ({DSP_RST, s_ready} !== 2'b10) begin
      fails++;
      $display("FAIL reset_release: DSP_RST,s_ready=%b required 10", {DSP_RST, s_ready});
    end
    @(negedge CLK);
    tests++;
    if ({DSP_RST, s_ready, DSP_CE} !== 3'b011) begin
      fails++;
      $display("FAIL reset_after: DSP_RST,s_ready,CE=%b required 011", {DSP_RST, s_ready, DSP_CE});
    end
  endtask

  task automatic test_back_to_back();
    logic found; int lat;
    send_pair(18'd2, 18'd3, 1'b0);
    send_pair(18'd4, 18'd5, 1'b1);
    wait_result(found, lat);
    tests++;
    if (lat !== 6) begin
      fails++;
      $display("FAIL b2b_latency: %0d cycles, required 6", lat);
    end
    tests++;
    if (m_data !== 48'd26 || m_count !== 16'd2) begin
      fails++;
      $display("FAIL b2b_result: m_data=%0d m_count=%0d required 26/2", m_data, m_count);
    end
    @(negedge CLK);
  endtask

  task automatic test_single_negative();
    logic found; int lat;
    send_pair(-18'sd7, 18'sd3, 1'b1);
    wait_result(found, lat);
    tests++;
    if (m_data !== 48'hFFFF_FFFF_FFEB || m_count !== 16'd1) begin
      fails++;
      $display("FAIL single_neg: m_data=%0h m_count=%0d required ffffffffffeb/1", m_data, m_count);
    end
    tests++;
    if (lat !== 6) begin
      fails++;
      $display("FAIL single_latency: %0d cycles, required 6", lat);
    end
    @(negedge CLK);
  endtask

  // Pairs at relative cycles 0, 4, 8 (last); result expected at cycle 14.
  task automatic test_gaps();
    for (int k = 0; k <= 15; k++) begin
      if (k == 3) begin
        tests++;
        if (DSP_OPMODE !== 8'h01) begin
          fails++;
          $display("FAIL gap_opm_first: cycle %0d OPMODE=%0h required 01", k, DSP_OPMODE);
        end
      end
      if (k >= 4 && k <= 13) begin
        tests++;
        if (DSP_OPMODE !== 8'h09) begin
          fails++;
          $display("FAIL gap_opm_acc: cycle %0d OPMODE=%0h required 09", k, DSP_OPMODE);
        end
      end
      if (k == 2) begin
        tests++;
        if ({DSP_A, DSP_B} !== 36'd0) begin
          fails++;
          $display("FAIL gap_bubble: A=%0h B=%0h required 0/0", DSP_A, DSP_B);
        end
      end
      if (k < 14) begin
        tests++;
        if (m_valid !== 1'b0) begin
          fails++;
          $display("FAIL gap_early_valid: cycle %0d m_valid=%b required 0", k, m_valid);
        end
      end
      if (k == 14) begin
        tests++;
        if (m_valid !== 1'b1 || m_data !== 48'd14 || m_count !== 16'd3) begin
          fails++;
          $display("FAIL gap_result: m_valid=%b m_data=%0d m_count=%0d required 1/14/3", m_valid, m_data, m_count);
        end
      end
      if (k == 0 || k == 4 || k == 8) begin
        tests++;
        if (s_ready !== 1'b1) begin
          fails++;
          $display("FAIL gap_ready: cycle %0d s_ready=%b required 1", k, s_ready);
        end
        s_valid = 1'b1;
        s_a = 18'(k / 4 + 1);
        s_b = 18'(k / 4 + 1);
        s_last = (k == 8);
      end else begin
        s_valid = 1'b0;
        s_last = 1'b0;
      end
      @(negedge CLK);
    end
    s_valid = 1'b0;
  endtask

  task automatic test_hold();
    logic found; int lat;
    m_ready = 1'b0;
    send_pair(18'd5, 18'd5, 1'b1);
    wait_result(found, lat);
    for (int i = 0; i < 10; i++) begin
      tests++;
      if (m_valid !== 1'b1 || m_data !== 48'd25 || m_count !== 16'd1 || s_ready !== 1'b0 || DSP_CE !== 1'b0) begin
        fails++;
        $display("FAIL hold_stable: i=%0d m_valid=%b m_data=%0d m_count=%0d s_ready=%b CE=%b required 1/25/1/0/0",
                 i, m_valid, m_data, m_count, s_ready, DSP_CE);
      end
      @(negedge CLK);
    end
    m_ready = 1'b1;
    @(negedge CLK);
    tests++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
      fails++;
      $display("FAIL hold_release: s_ready=%b m_valid=%b required 1/0", s_ready, m_valid);
    end
  endtask

  task automatic test_abort();
    logic found; int lat;
    send_pair(18'd1, 18'd2, 1'b0);
    send_pair(18'd3, 18'd4, 1'b0);
    @(negedge CLK);
    abort = 1'b1;
    @(negedge CLK);
    abort = 1'b0;
    tests++;
    if (DSP_RST !== 1'b1 || s_ready !== 1'b0) begin
      fails++;
      $display("FAIL abort_rst: DSP_RST=%b s_ready=%b required 1/0", DSP_RST, s_ready);
    end
    @(negedge CLK);
    tests++;
    if (DSP_RST !== 1'b0 || s_ready !== 1'b1) begin
      fails++;
      $display("FAIL abort_recover: DSP_RST=%b s_ready=%b required 0/1", DSP_RST, s_ready);
    end
    for (int i = 0; i < 10; i++) begin
      tests++;
      if (m_valid !== 1'b0) begin
        fails++;
        $display("FAIL abort_no_valid: i=%0d m_valid=%b required 0", i, m_valid);
      end
      @(negedge CLK);
    end
    send_pair(18'd6, 18'd7, 1'b1);
    wait_result(found, lat);
    tests++;
    if (m_data !== 48'd42 || m_count !== 16'd1) begin
      fails++;
      $display("FAIL abort_next: m_data=%0d m_count=%0d required 42/1", m_data, m_count);
    end
    @(negedge CLK);
  endtask

  task automatic test_max_and_reset();
    logic found; int lat;
    send_pair(18'd131071, 18'd131071, 1'b0);
    send_pair(18'd131071, 18'd131071, 1'b1);
    wait_result(found, lat);
    tests++;
    if (m_data !== 48'd34359214082 || m_count !== 16'd2) begin
      fails++;
      $display("FAIL max_result: m_data=%0d m_count=%0d required 34359214082/2", m_data, m_count);
    end
    @(negedge CLK);
    send_pair(18'd1, 18'd1, 1'b0);
    send_pair(18'd9, 18'd9, 1'b0);
    send_pair(18'd3, 18'd3, 1'b0);
    RSTN = 1'b0;
    #1;
    tests++;
    if ({s_ready, m_valid, DSP_CE, DSP_RST} !== 4'b0001) begin
      fails++;
      $display("FAIL midrst_ctrl: s_ready,m_valid,CE,RST=%b required 0001", {s_ready, m_valid, DSP_CE, DSP_RST});
    end
    tests++;
    if ({m_data, m_count, DSP_A, DSP_B, DSP_OPMODE} !== '0) begin
      fails++;
      $display("FAIL midrst_data: m_data=%0h m_count=%0h A=%0h B=%0h OPMODE=%0h required all 0",
               m_data, m_count, DSP_A, DSP_B, DSP_OPMODE);
    end
    @(negedge CLK);
    @(negedge CLK);
    RSTN = 1'b1;
    #1;
    tests++;
    if (DSP_RST !== 1'b1) begin
      fails++;
      $display("FAIL midrst_release: DSP_RST=%b required 1", DSP_RST);
    end
    @(negedge CLK);
    tests++;
    if (DSP_RST !== 1'b0 || s_ready !== 1'b1) begin
      fails++;
      $display("FAIL midrst_after: DSP_RST=%b s_ready=%b required 0/1", DSP_RST, s_ready);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_single_negative();
    test_gaps();
    test_hold();
    test_abort();
    test_max_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
